// File: rtl/verinject_outcome_classifier_if.sv
`default_nettype none
// ============================================================================
//  Module      : verinject_outcome_classifier_if
//  Description : Bundle between the fault-campaign driver (injector state,
//                cycle count, golden/injected outputs) and the outcome
//                classifier's per-injection report.
//  Revision    : 1.0 - initial release
// ============================================================================
interface verinject_outcome_classifier_if #(
  parameter int DATA_WIDTH  = 40,
  parameter int CYCLE_WIDTH = 48,
  parameter int COUNT_WIDTH = 16
);
  // Injector / design-under-fault side
  logic [31:0]             verinject__injector_state;
  logic [CYCLE_WIDTH-1:0]  cycle_number;
  logic [DATA_WIDTH-1:0]   real_data;
  logic [DATA_WIDTH-1:0]   inj_data;

  // Classification report
  logic                    busy;
  logic                    outcome_valid;
  logic [1:0]              outcome;
  logic [31:0]             inject_bit;
  logic [CYCLE_WIDTH-1:0]  inject_cycle;
  logic [CYCLE_WIDTH-1:0]  first_mismatch_cycle;
  logic [COUNT_WIDTH-1:0]  mismatch_count;
  logic                    overrun;

  // Campaign driver: produces injections and data, consumes reports
  modport master (
    output verinject__injector_state, cycle_number, real_data, inj_data,
    input  busy, outcome_valid, outcome, inject_bit, inject_cycle,
           first_mismatch_cycle, mismatch_count, overrun
  );

  // Classifier: consumes injections and data, produces reports
  modport slave (
    input  verinject__injector_state, cycle_number, real_data, inj_data,
    output busy, outcome_valid, outcome, inject_bit, inject_cycle,
           first_mismatch_cycle, mismatch_count, overrun
  );
endinterface
`default_nettype wire

// File: rtl/verinject_outcome_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : verinject_outcome_classifier
//  Description : Watches injector events, compares golden vs injected outputs
//                over a fixed window and classifies each fault as MASKED,
//                SDC or TRANSIENT, emitting one report per accepted injection.
//  Revision    : 1.0 - initial release
// ============================================================================
module verinject_outcome_classifier #(
  parameter int DATA_WIDTH  = 40,
  parameter int WINDOW      = 64,   // 2..65535
  parameter int CYCLE_WIDTH = 48,
  parameter int COUNT_WIDTH = 16
) (
  input  wire logic                  clock,
  input  wire logic                  reset,
  verinject_outcome_classifier_if.slave io_if
);

  // Window counter only needs to hold WINDOW itself
  localparam int c_WIN_W = $clog2(WINDOW + 1);
  localparam logic [c_WIN_W-1:0]     c_WINDOW      = c_WIN_W'(WINDOW);
  localparam logic [c_WIN_W-1:0]     c_WIN_LAST    = c_WIN_W'(1);
  localparam logic [CYCLE_WIDTH-1:0] c_NO_MISMATCH = '1;
  localparam logic [COUNT_WIDTH-1:0] c_COUNT_MAX   = '1;

  localparam logic [1:0] c_MASKED    = 2'd0;
  localparam logic [1:0] c_SDC       = 2'd1;
  localparam logic [1:0] c_TRANSIENT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OBSERVE = 2'd1,
    S_REPORT  = 2'd2
  } state_t;

  state_t                  r_state;
  logic [c_WIN_W-1:0]      r_win;
  logic                    r_busy;
  logic                    r_valid;
  logic [1:0]              r_outcome;
  logic [31:0]             r_inject_bit;
  logic [CYCLE_WIDTH-1:0]  r_inject_cycle;
  logic [CYCLE_WIDTH-1:0]  r_first_cycle;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic                    r_overrun;

  logic                    w_inject;
  logic                    w_mism;
  logic [COUNT_WIDTH-1:0]  w_count_next;
  logic [1:0]              w_final_outcome;

  // Per-sample compare, saturating count and the classification that applies
  // if the current sample is the last one of the window. The final sample's
  // mismatch is used directly so the report is ready in the REPORT cycle.
  always_comb begin
    w_inject        = (io_if.verinject__injector_state != 32'd0);
    w_mism          = (io_if.real_data != io_if.inj_data);
    w_count_next    = r_count;
    w_final_outcome = c_MASKED;
    if (w_mism && (r_count != c_COUNT_MAX)) begin
      w_count_next = r_count + COUNT_WIDTH'(1);
    end
    if (w_count_next == '0) begin
      w_final_outcome = c_MASKED;
    end else if (w_mism) begin
      w_final_outcome = c_SDC;
    end else begin
      w_final_outcome = c_TRANSIENT;
    end
  end

  // Observation FSM with registered report outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_win          <= '0;
      r_busy         <= 1'b0;
      r_valid        <= 1'b0;
      r_outcome      <= c_MASKED;
      r_inject_bit   <= '0;
      r_inject_cycle <= '0;
      r_first_cycle  <= c_NO_MISMATCH;
      r_count        <= '0;
      r_overrun      <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_inject) begin
            r_inject_bit   <= io_if.verinject__injector_state - 32'd1;
            r_inject_cycle <= io_if.cycle_number;
            r_count        <= '0;
            r_first_cycle  <= c_NO_MISMATCH;
            r_win          <= c_WINDOW;
            r_busy         <= 1'b1;
            r_state        <= S_OBSERVE;
          end
        end
        S_OBSERVE: begin
          // A zero count means no earlier mismatch: the counter saturates
          // and never wraps back to zero.
          if (w_mism && (r_count == '0)) begin
            r_first_cycle <= io_if.cycle_number;
          end
          r_count <= w_count_next;
          r_win   <= r_win - c_WIN_LAST;
          if (w_inject) begin
            r_overrun <= 1'b1;
          end
          if (r_win == c_WIN_LAST) begin
            r_outcome <= w_final_outcome;
            r_valid   <= 1'b1;
            r_state   <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (w_inject) begin
            r_overrun <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_if.busy                 = r_busy;
  assign io_if.outcome_valid        = r_valid;
  assign io_if.outcome              = r_outcome;
  assign io_if.inject_bit           = r_inject_bit;
  assign io_if.inject_cycle         = r_inject_cycle;
  assign io_if.first_mismatch_cycle = r_first_cycle;
  assign io_if.mismatch_count       = r_count;
  assign io_if.overrun              = r_overrun;

endmodule
`default_nettype wire
